// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath controls,
// counts retired instructions and traps on bus timeout. Define ILLEGAL_TRAP_EN to trap on illegal opcodes.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ir_wr,
  output logic             i_or_d,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_wr,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [4:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             bus_err,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_LUI = 5'd5;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               bus_err_q, bus_err_d;
  logic               illegal_q, illegal_d;
  logic               retire;

  logic       is_r, is_lw, is_sw, is_beq, is_addi, is_ori, is_lui, is_j;
  logic       r_ok, supported;
  logic [4:0] r_alu_op;

  // Instruction class decode straight from the IR fields.
  always_comb begin
    is_r    = (op == 6'h00);
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2B);
    is_beq  = (op == 6'h04);
    is_addi = (op == 6'h08);
    is_ori  = (op == 6'h0D);
    is_lui  = (op == 6'h0F);
    is_j    = (op == 6'h02);
    r_ok     = 1'b1;
    r_alu_op = ALU_ADD;
    case (funct)
      6'h20:   r_alu_op = ALU_ADD;
      6'h22:   r_alu_op = ALU_SUB;
      6'h24:   r_alu_op = ALU_AND;
      6'h25:   r_alu_op = ALU_OR;
      6'h2A:   r_alu_op = ALU_SLT;
      default: r_ok = 1'b0;
    endcase
    supported = (is_r && r_ok) || is_lw || is_sw || is_beq || is_addi ||
                is_ori || is_lui || is_j;
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    bus_err_d  = bus_err_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    ir_wr      = 1'b0;
    i_or_d     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    ext_op     = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          mem_rd    = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 2'd1;
        if (!supported) begin
          illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_d   = S_TRAP;
`else
          retire    = 1'b1;
          state_d   = S_FETCH;
`endif
        end else if (is_j) begin
          pc_wr   = 1'b1;
          pc_src  = 2'b10;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        if (is_r) begin
          alu_op  = r_alu_op;
          state_d = S_WB;
        end else if (is_lw || is_sw || is_addi) begin
          alu_src_b = 2'b10;
          ext_op    = 2'd1;
          state_d   = is_addi ? S_WB : S_MEM;
        end else if (is_ori) begin
          alu_src_b = 2'b10;
          alu_op    = ALU_OR;
          state_d   = S_WB;
        end else if (is_lui) begin
          alu_src_b = 2'b10;
          alu_op    = ALU_LUI;
          state_d   = S_WB;
        end else if (is_beq) begin
          alu_op  = ALU_SUB;
          pc_src  = 2'b01;
          pc_wr   = zero;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end

      // Strobes stay up through the wait so the memory sees a stable request.
      S_MEM: begin
        i_or_d = 1'b1;
        mem_rd = is_lw;
        mem_wr = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          mem_rd    = 1'b0;
          mem_wr    = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_FETCH;
    endcase

    // Reset must silence every enable at once, even before the clock edge.
    if (!rst) begin
      pc_wr      = 1'b0;
      pc_src     = 2'b00;
      ir_wr      = 1'b0;
      i_or_d     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_wr     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      ext_op     = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;
  assign bus_err   = bus_err_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected outputs, a monitor compares
// them on the falling edge. Honors ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_multicycle_ctrl;

  localparam int CW = 4;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op, funct;
  logic          zero, mem_ready;
  logic          pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_dst, mem_to_reg, reg_wr, alu_src_a;
  logic [1:0]    pc_src, alu_src_b, ext_op;
  logic [4:0]    alu_op;
  logic [2:0]    state;
  logic [CW-1:0] instr_cnt;
  logic          bus_err, illegal;

  multicycle_ctrl #(.CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .i_or_d(i_or_d), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
    .state(state), .instr_cnt(instr_cnt), .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          pcWr;
    logic [1:0]    pcSrc;
    logic          irWr;
    logic          iOrD;
    logic          memRd;
    logic          memWr;
    logic          regDst;
    logic          memToReg;
    logic          regWr;
    logic          srcA;
    logic [1:0]    srcB;
    logic [4:0]    aluOp;
    logic [1:0]    extOp;
    logic [CW-1:0] cnt;
    logic          busErr;
    logic          illegal;
  } outs_t;

  outs_t act;
  assign act = {state, pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, reg_dst, mem_to_reg,
                reg_wr, alu_src_a, alu_src_b, alu_op, ext_op, instr_cnt, bus_err, illegal};

  outs_t expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    fails  = 0;
  int    expCnt = 0;
  logic  expBusErr = 1'b0;
  logic  expIllegal = 1'b0;
  outs_t monExp;
  string monName;

  // st pw ps iw id mr mw rd m2r rw sa sb ao eo; flags come from the bench's running model
  function automatic outs_t mk(input int st, input int pw, input int ps, input int iw,
                               input int id, input int mr, input int mw, input int rd,
                               input int m2r, input int rw, input int sa, input int sb,
                               input int ao, input int eo);
    outs_t r;
    r.st = 3'(st);      r.pcWr = 1'(pw);     r.pcSrc = 2'(ps);   r.irWr = 1'(iw);
    r.iOrD = 1'(id);    r.memRd = 1'(mr);    r.memWr = 1'(mw);   r.regDst = 1'(rd);
    r.memToReg = 1'(m2r); r.regWr = 1'(rw);  r.srcA = 1'(sa);    r.srcB = 2'(sb);
    r.aluOp = 5'(ao);   r.extOp = 2'(eo);    r.cnt = CW'(expCnt);
    r.busErr = expBusErr; r.illegal = expIllegal;
    return r;
  endfunction

  task automatic checkOutput(input string nm, input outs_t a, input outs_t e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic applyStimulus(input string nm, input outs_t e);
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp  = expQ.pop_front();
      monName = nameQ.pop_front();
      checkOutput(monName, act, monExp);
    end
  end

  task automatic retireOne();
    expCnt = (expCnt + 1) % (1 << CW);
  endtask

  task automatic doFetch(input int waits);
    mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) applyStimulus("fetch_wait", mk(0,0,0,0,0,1,0,0,0,0,0,1,0,0));
    mem_ready = 1'b1;
    applyStimulus("fetch", mk(0,1,0,1,0,1,0,0,0,0,0,1,0,0));
  endtask

  task automatic doDecode();
    applyStimulus("decode", mk(1,0,0,0,0,0,0,0,0,0,0,3,0,1));
  endtask

  task automatic doR(input logic [5:0] f, input int aluExp);
    op = 6'h00; funct = f;
    doFetch(0); doDecode();
    applyStimulus("r_exec", mk(2,0,0,0,0,0,0,0,0,0,1,0,aluExp,0));
    applyStimulus("r_wb",   mk(4,0,0,0,0,0,0,1,0,1,0,0,0,0));
    retireOne();
  endtask

  task automatic doImm(input logic [5:0] o, input int aluExp, input int extExp);
    op = o; funct = 6'h00;
    doFetch(0); doDecode();
    applyStimulus("imm_exec", mk(2,0,0,0,0,0,0,0,0,0,1,2,aluExp,extExp));
    applyStimulus("imm_wb",   mk(4,0,0,0,0,0,0,0,0,1,0,0,0,0));
    retireOne();
  endtask

  task automatic doLw(input int memWaits);
    op = 6'h23;
    doFetch(0); doDecode();
    applyStimulus("lw_exec", mk(2,0,0,0,0,0,0,0,0,0,1,2,0,1));
    mem_ready = 1'b0;
    for (int i = 0; i < memWaits; i++) applyStimulus("lw_mem_wait", mk(3,0,0,0,1,1,0,0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    applyStimulus("lw_mem",  mk(3,0,0,0,1,1,0,0,0,0,0,0,0,0));
    applyStimulus("lw_wb",   mk(4,0,0,0,0,0,0,0,1,1,0,0,0,0));
    retireOne();
  endtask

  task automatic doSw();
    op = 6'h2B;
    doFetch(0); doDecode();
    applyStimulus("sw_exec", mk(2,0,0,0,0,0,0,0,0,0,1,2,0,1));
    applyStimulus("sw_mem",  mk(3,0,0,0,1,0,1,0,0,0,0,0,0,0));
    retireOne();
  endtask

  task automatic doBeq(input logic z);
    op = 6'h04; zero = z;
    doFetch(0); doDecode();
    applyStimulus(z ? "beq_taken" : "beq_not_taken", mk(2,int'(z),1,0,0,0,0,0,0,0,1,0,1,0));
    retireOne();
  endtask

  task automatic doJ(input int fetchWaits);
    op = 6'h02;
    doFetch(fetchWaits);
    applyStimulus("j_decode", mk(1,1,2,0,0,0,0,0,0,0,0,3,0,1));
    retireOne();
  endtask

  task automatic doReset();
    rst = 1'b0;
    expCnt = 0; expBusErr = 1'b0; expIllegal = 1'b0;
    applyStimulus("reset", mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
  endtask

  task automatic doIllegal(input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f;
    doFetch(0); doDecode();
    expIllegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    applyStimulus("illegal_trap", mk(7,0,0,0,0,0,0,0,0,0,0,0,0,0));
    applyStimulus("illegal_hold", mk(7,0,0,0,0,0,0,0,0,0,0,0,0,0));
`else
    retireOne();
    doJ(0);
`endif
    doReset();
  endtask

  initial begin
    rst = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    applyStimulus("reset_hold", mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;

    doR(6'h20, 0);
    doR(6'h22, 1);
    doR(6'h24, 2);
    doR(6'h25, 3);
    doR(6'h2A, 4);
    doLw(3);
    doSw();
    doBeq(1'b1);
    doBeq(1'b0);
    doJ(0);
    doImm(6'h08, 0, 1);
    doImm(6'h0D, 3, 0);
    doImm(6'h0F, 5, 0);
    doJ(MW - 1);
    for (int i = 0; i < 4; i++) doJ(0);

    // Abort a store that is waiting on memory.
    op = 6'h2B;
    doFetch(0); doDecode();
    applyStimulus("sw_exec2", mk(2,0,0,0,0,0,0,0,0,0,1,2,0,1));
    mem_ready = 1'b0;
    applyStimulus("sw_mem_stall", mk(3,0,0,0,1,0,1,0,0,0,0,0,0,0));
    rst = 1'b0;
    expCnt = 0;
    applyStimulus("rst_abort", mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    applyStimulus("after_rst", mk(0,0,0,0,0,1,0,0,0,0,0,1,0,0));
    doJ(0);

    // Bus timeout in FETCH, then TRAP must hold regardless of inputs.
    mem_ready = 1'b0;
    for (int i = 0; i < MW - 1; i++) applyStimulus("to_wait", mk(0,0,0,0,0,1,0,0,0,0,0,1,0,0));
    @(posedge clk); #1;
    expBusErr = 1'b1;
    mem_ready = 1'b1; op = 6'h23;
    applyStimulus("trap0", mk(7,0,0,0,0,0,0,0,0,0,0,0,0,0));
    mem_ready = 1'b0; op = 6'h00;
    applyStimulus("trap1", mk(7,0,0,0,0,0,0,0,0,0,0,0,0,0));
    doReset();

    doIllegal(6'h3F, 6'h00);
    doIllegal(6'h00, 6'h3F);
    doJ(0);

    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
